// File: rtl/fifo_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : fifo_pkg                                                   |
// | Brief   : Shared defaults and read-mode encodings for fifo_sync      |
// | Rev     : 1.0  initial release                                       |
// +----------------------------------------------------------------------+
package fifo_pkg;

  // Default geometry: 8-bit words, 16-entry storage
  localparam int c_DATASIZE_DEFAULT = 8;
  localparam int c_ADDRSIZE_DEFAULT = 4;

  // Read-mode selection for the FWFT parameter
  localparam int FWFT_OFF = 0;
  localparam int FWFT_ON  = 1;

endpackage : fifo_pkg
`default_nettype wire

// File: rtl/fifomem.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : fifomem                                                    |
// | Brief   : Dual-port RAM, synchronous write / asynchronous read       |
// | Rev     : 1.0  initial release                                       |
// +----------------------------------------------------------------------+
module fifomem #(
  parameter int DATASIZE = 8,
  parameter int ADDRSIZE = 4
) (
  input  logic                wclk,
  input  logic                wclken,
  input  logic                wfull,
  input  logic [ADDRSIZE-1:0] waddr,
  input  logic [ADDRSIZE-1:0] raddr,
  input  logic [DATASIZE-1:0] wdata,
  output logic [DATASIZE-1:0] rdata
);

  localparam int c_DEPTH = 2 ** ADDRSIZE;

  logic [DATASIZE-1:0] r_mem [c_DEPTH];

  assign rdata = r_mem[raddr];

  // Store the incoming word unless the FIFO is full
  always_ff @(posedge wclk) begin
    if (wclken && !wfull) begin
      r_mem[waddr] <= wdata;
    end
  end

endmodule : fifomem
`default_nettype wire

// File: rtl/fifo_sync.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : fifo_sync                                                  |
// | Brief   : Single-clock FIFO with count, almost flags, sticky errors  |
// |           and selectable registered / first-word-fall-through read   |
// | Rev     : 1.0  initial release                                       |
// +----------------------------------------------------------------------+
module fifo_sync
  import fifo_pkg::*;
#(
  parameter int DATASIZE   = c_DATASIZE_DEFAULT,
  parameter int ADDRSIZE   = c_ADDRSIZE_DEFAULT,
  parameter int AFULL_LVL  = 2 ** ADDRSIZE - 2,
  parameter int AEMPTY_LVL = 2,
  parameter int FWFT       = FWFT_OFF
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [DATASIZE-1:0] wdata,
  input  logic                winc,
  input  logic                rinc,
  input  logic                clr_err,
  output logic [DATASIZE-1:0] rdata,
  output logic                wfull,
  output logic                rempty,
  output logic                walmost_full,
  output logic                ralmost_empty,
  output logic [ADDRSIZE:0]   count,
  output logic                overflow,
  output logic                underflow
);

  // Thresholds fit in ADDRSIZE+1 bits because they are bounded by the depth
  localparam logic [ADDRSIZE:0] c_AFULL   = AFULL_LVL[ADDRSIZE:0];
  localparam logic [ADDRSIZE:0] c_AEMPTY  = AEMPTY_LVL[ADDRSIZE:0];
  localparam logic [ADDRSIZE:0] c_PTR_ONE = 1;

  // Thresholds beyond the depth can never be met sensibly
  if (AFULL_LVL > 2 ** ADDRSIZE) begin : g_bad_afull
    $error("fifo_sync: AFULL_LVL exceeds FIFO depth");
  end
  if (AEMPTY_LVL > 2 ** ADDRSIZE) begin : g_bad_aempty
    $error("fifo_sync: AEMPTY_LVL exceeds FIFO depth");
  end

  logic [ADDRSIZE:0]   r_wptr;
  logic [ADDRSIZE:0]   r_rptr;
  logic                r_overflow;
  logic                r_underflow;
  logic [ADDRSIZE:0]   w_count;
  logic                w_full;
  logic                w_empty;
  logic                w_wr_en;
  logic                w_rd_en;
  logic [DATASIZE-1:0] w_mem_rdata;

  // Status is a pure decode of the pointer registers; the extra MSB
  // distinguishes full from empty when the address bits coincide
  assign w_full  = (r_wptr[ADDRSIZE] != r_rptr[ADDRSIZE]) &&
                   (r_wptr[ADDRSIZE-1:0] == r_rptr[ADDRSIZE-1:0]);
  assign w_empty = (r_wptr == r_rptr);
  assign w_count = r_wptr - r_rptr;
  assign w_wr_en = winc && !w_full;
  assign w_rd_en = rinc && !w_empty;

  assign wfull         = w_full;
  assign rempty        = w_empty;
  assign count         = w_count;
  assign walmost_full  = (w_count >= c_AFULL);
  assign ralmost_empty = (w_count <= c_AEMPTY);
  assign overflow      = r_overflow;
  assign underflow     = r_underflow;

  fifomem #(
    .DATASIZE (DATASIZE),
    .ADDRSIZE (ADDRSIZE)
  ) u_mem (
    .wclk   (clk),
    .wclken (winc),
    .wfull  (w_full),
    .waddr  (r_wptr[ADDRSIZE-1:0]),
    .raddr  (r_rptr[ADDRSIZE-1:0]),
    .wdata  (wdata),
    .rdata  (w_mem_rdata)
  );

  // Advance pointers on accepted transfers; reset overrides any request
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else begin
      if (w_wr_en) r_wptr <= r_wptr + c_PTR_ONE;
      if (w_rd_en) r_rptr <= r_rptr + c_PTR_ONE;
    end
  end

  // Sticky error flags; a new error wins over a simultaneous clear
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      if (winc && w_full)       r_overflow  <= 1'b1;
      else if (clr_err)         r_overflow  <= 1'b0;
      if (rinc && w_empty)      r_underflow <= 1'b1;
      else if (clr_err)         r_underflow <= 1'b0;
    end
  end

  if (FWFT == FWFT_OFF) begin : g_rd_registered
    logic [DATASIZE-1:0] r_rdata;

    // Capture the head word on the edge of an accepted read
    always_ff @(posedge clk) begin
      if (!rst_n) begin
        r_rdata <= '0;
      end else if (w_rd_en) begin
        r_rdata <= w_mem_rdata;
      end
    end

    assign rdata = r_rdata;
  end else begin : g_rd_fwft
    assign rdata = w_mem_rdata;
  end

endmodule : fifo_sync
`default_nettype wire
